// File: rtl/etc_semiring_mma_pkg.sv
// Semiring tile MMA shared definitions: op encoding, per-op identity and saturating add.
// Helpers are width-generic up to ETC_MAXW bits; callers slice the low W bits.
package etc_pkg;

   localparam int ETC_MAXW = 64;

   typedef enum logic [1:0] {
      ETC_MUL_ADD  = 2'd0,
      ETC_OR_AND   = 2'd1,
      ETC_MIN_PLUS = 2'd2,
      ETC_MAX_PLUS = 2'd3
   } etc_op_e;

   typedef logic [ETC_MAXW-1:0] etc_word_t;

   function automatic etc_word_t etcMask(input int w);
      etc_word_t m;
      if (w >= ETC_MAXW) m = '1;
      else               m = (etc_word_t'(1) << w) - etc_word_t'(1);
      return m;
   endfunction

   // Identity of the (+) reduction; all-ones doubles as "infinity" for MIN_PLUS.
   function automatic etc_word_t etcIdentity(input etc_op_e op, input int w);
      etc_word_t id;
      case (op)
         ETC_OR_AND, ETC_MIN_PLUS: id = etcMask(w);
         default:                  id = '0;
      endcase
      return id;
   endfunction

   function automatic etc_word_t etcSatAdd(input etc_word_t a, input etc_word_t b, input int w);
      logic [ETC_MAXW:0] s;
      etc_word_t         r;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, etcMask(w)}) r = etcMask(w);
      else                        r = s[ETC_MAXW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/etc_semiring_mma_if.sv
// Tile-level valid/ready bundle between a producer, the MMA block and a result consumer.
interface etc_semiring_mma_if #(
   parameter int W = 16,
   parameter int N = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic             in_acc_en;
   logic [N*N*W-1:0] in_a;
   logic [N*N*W-1:0] in_b;
   logic [N*N*W-1:0] in_c;
   logic             out_valid;
   logic             out_ready;
   logic [N*N*W-1:0] out_d;
   logic [1:0]       out_op;

   modport master (
      output in_valid, in_op, in_acc_en, in_a, in_b, in_c, out_ready,
      input  in_ready, out_valid, out_d, out_op
   );

   modport slave (
      input  in_valid, in_op, in_acc_en, in_a, in_b, in_c, out_ready,
      output in_ready, out_valid, out_d, out_op
   );
endinterface

// File: rtl/etc_semiring_mma_pe.sv
// One output element: N (x) ops and the C' select registered on advance, then a (+) tree and C' fold.
// Holds its stage register when advance is low; pipeline control lives in the parent.
module etc_semiring_pe
   import etc_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           advance,
   input  etc_op_e        mulOp,
   input  logic           accEn,
   input  logic [N*W-1:0] aRow,
   input  logic [N*W-1:0] bCol,
   input  logic [W-1:0]   cIn,
   input  etc_op_e        redOp,
   output logic [W-1:0]   dOut
);

   logic [N-1:0][W-1:0]   prodNext;
   logic [N-1:0][W-1:0]   prodQ;
   logic [W-1:0]          cPrimeNext;
   logic [W-1:0]          cPrimeQ;
   logic [2*N-2:0][W-1:0] node;
   etc_word_t             aExt;
   etc_word_t             bExt;
   etc_word_t             satSum;
   etc_word_t             ident;

   function automatic logic [W-1:0] combine(input etc_op_e op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      logic [W-1:0] r;
      case (op)
         ETC_MUL_ADD:  r = x + y;
         ETC_OR_AND:   r = x & y;
         ETC_MIN_PLUS: r = (x < y) ? x : y;
         default:      r = (x > y) ? x : y;
      endcase
      return r;
   endfunction

   always_comb begin
      prodNext = '0;
      aExt     = '0;
      bExt     = '0;
      satSum   = '0;
      for (int k = 0; k < N; k++) begin
         aExt         = '0;
         bExt         = '0;
         aExt[W-1:0]  = aRow[k*W +: W];
         bExt[W-1:0]  = bCol[k*W +: W];
         satSum       = etcSatAdd(aExt, bExt, W);
         case (mulOp)
            ETC_MUL_ADD: prodNext[k] = aRow[k*W +: W] * bCol[k*W +: W];
            ETC_OR_AND:  prodNext[k] = aRow[k*W +: W] | bCol[k*W +: W];
            default:     prodNext[k] = satSum[W-1:0];
         endcase
      end
      ident      = etcIdentity(mulOp, W);
      cPrimeNext = accEn ? cIn : ident[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         prodQ   <= prodNext;
         cPrimeQ <= cPrimeNext;
      end
   end

   // Heap-shaped tree: leaves at N-1..2N-2, every internal node has two children for any N.
   always_comb begin
      node = '0;
      for (int k = 0; k < N; k++) node[N-1+k] = prodQ[k];
      for (int i = N-2; i >= 0; i--) node[i] = combine(redOp, node[2*i+1], node[2*i+2]);
      dOut = combine(redOp, cPrimeQ, node[0]);
   end

endmodule

// File: rtl/etc_semiring_mma.sv
// N x N semiring tile multiply-accumulate, 3-stage pipeline (3-cycle latency, 1 tile/cycle).
// A held output freezes every stage and drops in_ready combinationally; bubbles always advance.
module etc_semiring_mma
   import etc_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 4
) (
   input logic               clk,
   input logic               rst_n,
   etc_semiring_mma_if.slave bus
);

   localparam int TILE = N*N*W;

   logic            advance;
   logic            v1;
   logic            v2;
   logic            outValid;
   logic [TILE-1:0] a1;
   logic [TILE-1:0] b1;
   logic [TILE-1:0] c1;
   etc_op_e         op1;
   etc_op_e         op2;
   logic            acc1;
   logic [TILE-1:0] dNext;
   logic [TILE-1:0] outD;
   logic [1:0]      outOp;

   assign advance       = ~(outValid & ~bus.out_ready);
   assign bus.in_ready  = advance;
   assign bus.out_valid = outValid;
   assign bus.out_d     = outD;
   assign bus.out_op    = outOp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         outValid <= 1'b0;
         outD     <= '0;
         outOp    <= '0;
      end else if (advance) begin
         v1       <= bus.in_valid;
         v2       <= v1;
         outValid <= v2;
         // Only real results reach out_d, so unreset upstream data never shows up there.
         if (v2) begin
            outD  <= dNext;
            outOp <= op2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         a1   <= bus.in_a;
         b1   <= bus.in_b;
         c1   <= bus.in_c;
         op1  <= etc_op_e'(bus.in_op);
         acc1 <= bus.in_acc_en;
         op2  <= op1;
      end
   end

   for (genvar i = 0; i < N; i++) begin : gRow
      for (genvar j = 0; j < N; j++) begin : gCol
         logic [N*W-1:0] bCol;

         always_comb begin
            bCol = '0;
            for (int k = 0; k < N; k++) bCol[k*W +: W] = b1[(k*N+j)*W +: W];
         end

         etc_semiring_pe #(.W(W), .N(N)) uPe (
            .clk     (clk),
            .advance (advance),
            .mulOp   (op1),
            .accEn   (acc1),
            .aRow    (a1[i*N*W +: N*W]),
            .bCol    (bCol),
            .cIn     (c1[(i*N+j)*W +: W]),
            .redOp   (op2),
            .dOut    (dNext[(i*N+j)*W +: W])
         );
      end
   end

endmodule

// File: tb/tb_etc_semiring_mma.sv
// Self-checking bench for etc_semiring_mma: directed semiring cases, stall, random traffic, reset flush.
module tb_etc_semiring_mma;

   localparam int TW    = 16;
   localparam int TN    = 4;
   localparam int TBITS = TW*TN*TN;
   localparam longint unsigned MAXV = 64'd65535;

   typedef logic [TBITS-1:0] tile_t;
   typedef struct { logic [1:0] op; logic acc; tile_t a; tile_t b; tile_t c; int cyc; } in_rec_t;
   typedef struct { tile_t d; logic [1:0] op; int cyc; } out_rec_t;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   int      cyc      = 0;
   int      n_checks = 0;
   int      n_fail   = 0;
   in_rec_t  inQ[$];
   out_rec_t outQ[$];

   etc_semiring_mma_if #(.W(TW), .N(TN)) bus();

   etc_semiring_mma #(.W(TW), .N(TN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      in_rec_t  ir;
      out_rec_t orc;
      if (rst_n && bus.in_valid && bus.in_ready) begin
         ir.op = bus.in_op; ir.acc = bus.in_acc_en;
         ir.a = bus.in_a; ir.b = bus.in_b; ir.c = bus.in_c; ir.cyc = cyc;
         inQ.push_back(ir);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
         orc.d = bus.out_d; orc.op = bus.out_op; orc.cyc = cyc;
         outQ.push_back(orc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got time limit reached, want self-termination");
      $fatal(1, "watchdog");
   end

   // Reference: textbook semiring matrix product over integers, clipped to TW bits.
   function automatic tile_t ref_mma(input logic [1:0] op, input logic acc,
                                     input tile_t a, input tile_t b, input tile_t c);
      tile_t d = '0;
      for (int i = 0; i < TN; i++) begin
         for (int j = 0; j < TN; j++) begin
            longint unsigned r, x, y, s;
            if (acc) r = 64'(c[(i*TN+j)*TW +: TW]);
            else     r = (op == 2'd1 || op == 2'd2) ? MAXV : 64'd0;
            for (int k = 0; k < TN; k++) begin
               x = 64'(a[(i*TN+k)*TW +: TW]);
               y = 64'(b[(k*TN+j)*TW +: TW]);
               s = (x + y > MAXV) ? MAXV : x + y;
               case (op)
                  2'd0:    r = (r + x*y) % (MAXV + 1);
                  2'd1:    r = r & (x | y);
                  2'd2:    r = (s < r) ? s : r;
                  default: r = (s > r) ? s : r;
               endcase
            end
            d[(i*TN+j)*TW +: TW] = r[TW-1:0];
         end
      end
      return d;
   endfunction

   function automatic logic [TW-1:0] rand_elem();
      logic [TW-1:0] v;
      case ($urandom_range(0, 3))
         0:       v = '0;
         1:       v = '1;
         2:       v = TW'($urandom_range(0, 15));
         default: v = TW'($urandom);
      endcase
      return v;
   endfunction

   function automatic tile_t rand_tile();
      tile_t t;
      for (int e = 0; e < TN*TN; e++) t[e*TW +: TW] = rand_elem();
      return t;
   endfunction

   task automatic send_tile(input logic [1:0] op, input logic acc,
                            input tile_t a, input tile_t b, input tile_t c);
      int guard = 0;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_acc_en = acc;
      bus.in_a = a; bus.in_b = b; bus.in_c = c;
      @(negedge clk);
      while (!bus.in_ready && guard < 200) begin guard++; @(negedge clk); end
      if (!bus.in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_tile_timeout: got in_ready=%0b want 1", bus.in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out(input int k, input int budget);
      int n = 0;
      while (outQ.size() < k && n < budget) begin @(posedge clk); #1; n++; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_d !== tile_t'(0)) begin n_fail++; $display("FAIL reset_out_d: got %h want 0", bus.out_d); end
      n_checks++; if (bus.out_op !== 2'd0) begin n_fail++; $display("FAIL reset_out_op: got %0d want 0", bus.out_op); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      n_checks++; if (outQ.size() != 0) begin n_fail++; $display("FAIL reset_idle_output: got %0d outputs want 0", outQ.size()); end
   endtask

   task automatic test_directed();
      for (int t = 0; t < 4; t++) begin
         tile_t a, b, c, exp;
         logic [1:0] op;
         logic acc;
         for (int i = 0; i < TN; i++) begin
            for (int j = 0; j < TN; j++) begin
               case (t)
                  0: begin
                     a[(i*TN+j)*TW +: TW] = (i == j) ? TW'(1) : TW'(0);
                     b[(i*TN+j)*TW +: TW] = TW'(i*TN + j);
                     c[(i*TN+j)*TW +: TW] = rand_elem();
                     exp[(i*TN+j)*TW +: TW] = TW'(i*TN + j);
                  end
                  1: begin
                     a[(i*TN+j)*TW +: TW] = (i == 0 && j == 1) ? TW'(3) : 16'hFFFF;
                     b[(i*TN+j)*TW +: TW] = (i == 1 && j == 2) ? TW'(4) : 16'hFFFF;
                     c[(i*TN+j)*TW +: TW] = (i == 0 && j == 2) ? TW'(5) : 16'hFFFF;
                     exp[(i*TN+j)*TW +: TW] = (i == 0 && j == 2) ? TW'(5) : 16'hFFFF;
                  end
                  2: begin
                     a[(i*TN+j)*TW +: TW] = 16'h00F0;
                     b[(i*TN+j)*TW +: TW] = 16'h0F00;
                     c[(i*TN+j)*TW +: TW] = 16'hFFF0;
                     exp[(i*TN+j)*TW +: TW] = 16'h0FF0;
                  end
                  default: begin
                     a[(i*TN+j)*TW +: TW] = 16'h0100;
                     b[(i*TN+j)*TW +: TW] = 16'h0100;
                     c[(i*TN+j)*TW +: TW] = 16'h0001;
                     exp[(i*TN+j)*TW +: TW] = 16'h0001;
                  end
               endcase
            end
         end
         op  = (t == 1) ? 2'd2 : (t == 2) ? 2'd1 : 2'd0;
         acc = (t != 0);
         inQ.delete(); outQ.delete();
         send_tile(op, acc, a, b, c);
         bus.in_valid = 1'b0;
         wait_out(1, 20);
         n_checks++;
         if (outQ.size() != 1 || inQ.size() != 1) begin
            n_fail++; $display("FAIL directed%0d_count: got %0d outputs want 1", t, outQ.size());
         end else begin
            n_checks++; if (outQ[0].d !== exp) begin n_fail++; $display("FAIL directed%0d_data: got %h want %h", t, outQ[0].d, exp); end
            n_checks++; if (outQ[0].op !== op) begin n_fail++; $display("FAIL directed%0d_op: got %0d want %0d", t, outQ[0].op, op); end
            n_checks++; if (outQ[0].cyc - inQ[0].cyc != 3) begin n_fail++; $display("FAIL directed%0d_latency: got %0d want 3", t, outQ[0].cyc - inQ[0].cyc); end
         end
         repeat (2) @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      tile_t a[4], b[4], c[4], held, exp;
      logic  acc[4];
      for (int t = 0; t < 4; t++) begin
         a[t] = rand_tile(); b[t] = rand_tile(); c[t] = rand_tile(); acc[t] = 1'($urandom_range(0, 1));
      end
      inQ.delete(); outQ.delete();
      fork
         begin
            for (int t = 0; t < 4; t++) send_tile(2'(t), acc[t], a[t], b[t], c[t]);
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk); #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk); #1 bus.out_ready = 1'b1;
         end
         begin
            repeat (3) @(posedge clk);
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_out_valid: got %b want 1", s, bus.out_valid); end
               n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_in_ready: got %b want 0", s, bus.in_ready); end
               if (s == 0) held = bus.out_d;
               if (s == 2) begin
                  n_checks++; if (bus.out_d !== held) begin n_fail++; $display("FAIL stall_out_d_stable: got %h want %h", bus.out_d, held); end
               end
            end
         end
      join
      wait_out(4, 50);
      repeat (5) @(posedge clk); #1;
      n_checks++; if (inQ.size() != 4) begin n_fail++; $display("FAIL b2b_in_count: got %0d want 4", inQ.size()); end
      n_checks++; if (outQ.size() != 4) begin n_fail++; $display("FAIL b2b_out_count: got %0d want 4", outQ.size()); end
      for (int t = 0; t < 4 && t < outQ.size(); t++) begin
         exp = ref_mma(2'(t), acc[t], a[t], b[t], c[t]);
         n_checks++; if (outQ[t].d !== exp) begin n_fail++; $display("FAIL b2b%0d_data: got %h want %h", t, outQ[t].d, exp); end
         n_checks++; if (outQ[t].op !== 2'(t)) begin n_fail++; $display("FAIL b2b%0d_op: got %0d want %0d", t, outQ[t].op, t); end
      end
   endtask

   task automatic test_random();
      localparam int NT = 60;
      tile_t exp;
      inQ.delete(); outQ.delete();
      fork
         begin
            for (int t = 0; t < NT; t++) begin
               send_tile(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_tile(), rand_tile(), rand_tile());
               if ($urandom_range(0, 3) == 0) begin
                  bus.in_valid = 1'b0;
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            bus.in_valid = 1'b0;
         end
         begin
            int g = 0;
            while (outQ.size() < NT && g < 3000) begin
               @(posedge clk); #1 bus.out_ready = ($urandom_range(0, 2) != 0);
               g++;
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_out(NT, 50);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (inQ.size() != NT) begin n_fail++; $display("FAIL rand_in_count: got %0d want %0d", inQ.size(), NT); end
      n_checks++; if (outQ.size() != NT) begin n_fail++; $display("FAIL rand_out_count: got %0d want %0d", outQ.size(), NT); end
      for (int t = 0; t < inQ.size() && t < outQ.size(); t++) begin
         exp = ref_mma(inQ[t].op, inQ[t].acc, inQ[t].a, inQ[t].b, inQ[t].c);
         n_checks++; if (outQ[t].d !== exp) begin n_fail++; $display("FAIL rand%0d_data: got %h want %h", t, outQ[t].d, exp); end
         n_checks++; if (outQ[t].op !== inQ[t].op) begin n_fail++; $display("FAIL rand%0d_op: got %0d want %0d", t, outQ[t].op, inQ[t].op); end
      end
   endtask

   task automatic test_reset_flush();
      tile_t a, b, c, exp;
      inQ.delete(); outQ.delete();
      send_tile(2'd0, 1'b1, rand_tile(), rand_tile(), rand_tile());
      send_tile(2'd2, 1'b0, rand_tile(), rand_tile(), rand_tile());
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_d !== tile_t'(0)) begin n_fail++; $display("FAIL flush_out_d: got %h want 0", bus.out_d); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (8) @(posedge clk); #1;
      n_checks++; if (outQ.size() != 0) begin n_fail++; $display("FAIL flush_no_output: got %0d outputs want 0", outQ.size()); end
      inQ.delete(); outQ.delete();
      a = rand_tile(); b = rand_tile(); c = rand_tile();
      send_tile(2'd3, 1'b1, a, b, c);
      bus.in_valid = 1'b0;
      wait_out(1, 20);
      exp = ref_mma(2'd3, 1'b1, a, b, c);
      n_checks++;
      if (outQ.size() != 1 || inQ.size() != 1) begin
         n_fail++; $display("FAIL flush_post_count: got %0d outputs want 1", outQ.size());
      end else begin
         n_checks++; if (outQ[0].d !== exp) begin n_fail++; $display("FAIL flush_post_data: got %h want %h", outQ[0].d, exp); end
         n_checks++; if (outQ[0].op !== 2'd3) begin n_fail++; $display("FAIL flush_post_op: got %0d want 3", outQ[0].op); end
         n_checks++; if (outQ[0].cyc - inQ[0].cyc != 3) begin n_fail++; $display("FAIL flush_post_latency: got %0d want 3", outQ[0].cyc - inQ[0].cyc); end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'd0;
      bus.in_acc_en = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
